pipe_ctrl: RTL

Pipeline hold/flush scheduler for the five-stage core. It watches the EX stage (jumps, loads, multi-cycle ops) and the ID stage (source registers). It drives the hold and flush controls of pc_reg, if_id and id_ex. A flush makes id_ex load its NOP set values (INST_NOP, ZeroWord, ZeroReg, WriteDisable); a hold keeps its current contents. A registered state machine sequences multi-cycle EX operations, with a bounded wait and error reporting.

---
 rtl/pipe_ctrl_if.sv | 53 +++++
 rtl/pipe_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard/control bundle between the pipeline datapath and pipe_ctrl.
//
// Signals:
//   EX side   : jump_en_i, jump_addr_i, ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i
//   ID side   : id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i
//   MC unit   : mc_start_i, mc_done_i
//   Controls  : jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
//               flush_if_id_o, flush_id_ex_o, mc_err_o
//   Perf      : stall_cnt_o, flush_cnt_o
//
// Modports:
//   master : the scheduler (pipe_ctrl) -- consumes hazard info, drives controls
//   slave  : the datapath side -- drives hazard info, consumes controls
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_is_load_i;
    logic        ex_reg_wen_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        mc_start_i;
    logic        mc_done_i;

    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        mc_err_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        input  jump_en_i, jump_addr_i, ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               mc_start_i, mc_done_i,
        output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, mc_err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               mc_start_i, mc_done_i,
        input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, mc_err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hold/flush scheduler for the five-stage core.
//
// Resolves taken jumps (flush IF/ID and ID/EX, redirect PC), load-use hazards
// (one-cycle bubble into ID/EX) and multi-cycle EX operations (freeze the
// front of the pipe until the unit reports done, abort after MC_TIMEOUT cycles).
//
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipe_ctrl_if.master, hazard inputs and stage controls
//
// Parameters:
//   MC_TIMEOUT : max cycles held for one multi-cycle op (2..65535)
//
// Build option:
//   PIPE_CTRL_PERF_EN : when defined, builds saturating stall/jump counters on
//                       stall_cnt_o / flush_cnt_o; otherwise both read as 0.
//
// States:
//   state   | meaning
//   IDLE    | normal flow; jump / mc_start / load-use resolved combinationally
//   MC_WAIT | multi-cycle op in flight; pipe frozen until done or timeout
module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    // Entry cycle is held while still in IDLE, so MC_WAIT covers the remaining
    // MC_TIMEOUT-1 held cycles; the counter starts at 0 and the last one is
    // reached when it reads MC_TIMEOUT-2.
    localparam logic [15:0] LAST_CNT = 16'(MC_TIMEOUT - 2);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic        mc_err_q;
    logic        load_use;
    logic        timeout_hit;

    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_pc;
    logic        hold_if_id;
    logic        hold_id_ex;
    logic        flush_if_id;
    logic        flush_id_ex;

    assign load_use = bus.ex_is_load_i && bus.ex_reg_wen_i && (bus.ex_rd_addr_i != 5'd0) &&
                      ((bus.id_rs1_used_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                       (bus.id_rs2_used_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

    assign timeout_hit = (state == MC_WAIT) && !bus.mc_done_i && (wait_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter and error pulse; counter is parked at 0 in IDLE so it is
    // clear on every entry to MC_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 16'd0;
            mc_err_q <= 1'b0;
        end else begin
            mc_err_q <= timeout_hit;
            if (state == MC_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= 16'd0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.jump_en_i && bus.mc_start_i) begin
                    state_nxt = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (bus.mc_done_i || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; everything is forced low while rst is asserted.
    always_comb begin
        jump_en     = 1'b0;
        jump_addr   = 32'd0;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.jump_en_i) begin
                        jump_en     = 1'b1;
                        jump_addr   = bus.jump_addr_i;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (bus.mc_start_i) begin
                        hold_pc    = 1'b1;
                        hold_if_id = 1'b1;
                        hold_id_ex = 1'b1;
                    end else if (load_use) begin
                        // Freeze IF/ID, push a NOP into ID/EX: one bubble.
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // Done releases the pipe in the same cycle.
                    hold_pc    = !bus.mc_done_i;
                    hold_if_id = !bus.mc_done_i;
                    hold_id_ex = !bus.mc_done_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.jump_en_o     = jump_en;
    assign bus.jump_addr_o   = jump_addr;
    assign bus.hold_pc_o     = hold_pc;
    assign bus.hold_if_id_o  = hold_if_id;
    assign bus.hold_id_ex_o  = hold_id_ex;
    assign bus.flush_if_id_o = flush_if_id;
    assign bus.flush_id_ex_o = flush_id_ex;
    assign bus.mc_err_o      = mc_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (hold_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (jump_en && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`else
    assign bus.stall_cnt_o = 32'd0;
    assign bus.flush_cnt_o = 32'd0;
`endif

endmodule
